mul_arbiter: RTL and testbench

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arbiter.sv | 137 +++++++++++++
 tb/tb_mul_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// Two-requester round-robin front end sharing one 8-bit combinational multiplier.
// Optional macro MUL_ARB_ZERO_BYPASS_EN: zero operands complete in IDLE without waiting.

module mul8 (
   input  logic [7:0] INPUT1,
   input  logic [7:0] INPUT2,
   output logic [7:0] OUT
);
   assign OUT = INPUT1 * INPUT2;
endmodule

module mul_arbiter #(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       REQ0,
   input  logic       REQ1,
   input  logic [7:0] A0,
   input  logic [7:0] B0,
   input  logic [7:0] A1,
   input  logic [7:0] B1,
   output logic       GNT0,
   output logic       GNT1,
   output logic       DONE0,
   output logic       DONE1,
   output logic [7:0] RESULT,
   output logic       BUSY
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_t;

   localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

   state_t     r_state;
   logic       r_last;
   logic [3:0] r_cnt;
   logic [7:0] r_opa;
   logic [7:0] r_opb;
   logic [7:0] r_result;
   logic       r_gnt0;
   logic       r_gnt1;
   logic       r_done0;
   logic       r_done1;

   logic       w_req_any;
   logic       w_sel;
   logic [7:0] w_sel_a;
   logic [7:0] w_sel_b;
   logic [7:0] w_prod;
   logic       w_bypass;

   mul8 u_mul (
      .INPUT1 (r_opa),
      .INPUT2 (r_opb),
      .OUT    (w_prod)
   );

   // On a tie the requester not served last wins; otherwise whoever is asking.
   assign w_req_any = REQ0 | REQ1;
   assign w_sel     = (REQ0 & REQ1) ? ~r_last : REQ1;
   assign w_sel_a   = w_sel ? A1 : A0;
   assign w_sel_b   = w_sel ? B1 : B0;

`ifdef MUL_ARB_ZERO_BYPASS_EN
   assign w_bypass = (w_sel_a == '0) || (w_sel_b == '0);
`else
   assign w_bypass = 1'b0;
`endif

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state  <= S_IDLE;
         r_last   <= 1'b1;
         r_cnt    <= '0;
         r_opa    <= '0;
         r_opb    <= '0;
         r_result <= '0;
         r_gnt0   <= 1'b0;
         r_gnt1   <= 1'b0;
         r_done0  <= 1'b0;
         r_done1  <= 1'b0;
      end else begin
         r_gnt0  <= 1'b0;
         r_gnt1  <= 1'b0;
         r_done0 <= 1'b0;
         r_done1 <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_req_any) begin
                  r_opa  <= w_sel_a;
                  r_opb  <= w_sel_b;
                  r_last <= w_sel;
                  r_gnt0 <= ~w_sel;
                  r_gnt1 <= w_sel;
                  if (w_bypass) begin
                     r_result <= '0;
                     r_done0  <= ~w_sel;
                     r_done1  <= w_sel;
                     r_cnt    <= '0;
                     r_state  <= S_DONE;
                  end else begin
                     r_cnt   <= LP_WAIT;
                     r_state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               // r_last already names the requester being served.
               if (r_cnt == 4'd1) begin
                  r_result <= w_prod;
                  r_done0  <= ~r_last;
                  r_done1  <= r_last;
                  r_cnt    <= '0;
                  r_state  <= S_DONE;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign GNT0   = r_gnt0;
   assign GNT1   = r_gnt1;
   assign DONE0  = r_done0;
   assign DONE1  = r_done1;
   assign RESULT = r_result;
   assign BUSY   = (r_state != S_IDLE);

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: directed scenarios plus random traffic against a transaction-timeline model.
// Honours MUL_ARB_ZERO_BYPASS_EN when defined for the build.

module tb_mul_arbiter;

   localparam int W = 2;

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic       REQ0 = 1'b0;
   logic       REQ1 = 1'b0;
   logic [7:0] A0 = '0;
   logic [7:0] B0 = '0;
   logic [7:0] A1 = '0;
   logic [7:0] B1 = '0;
   logic       GNT0;
   logic       GNT1;
   logic       DONE0;
   logic       DONE1;
   logic [7:0] RESULT;
   logic       BUSY;

   mul_arbiter #(.WAIT_CYCLES(W)) dut (
      .CLK    (CLK),
      .RESET  (RESET),
      .REQ0   (REQ0),
      .REQ1   (REQ1),
      .A0     (A0),
      .B0     (B0),
      .A1     (A1),
      .B1     (B1),
      .GNT0   (GNT0),
      .GNT1   (GNT1),
      .DONE0  (DONE0),
      .DONE1  (DONE1),
      .RESULT (RESULT),
      .BUSY   (BUSY)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;

   // Model: each operation is a grant edge plus a latency; outputs follow from edge arithmetic.
   int         n      = 0;
   int         g_edge = -1000;
   int         lat    = 0;
   int         who    = 0;
   int         last   = 1;
   logic [7:0] prod   = '0;
   logic [7:0] res_exp = '0;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      g_edge  = -1000;
      lat     = 0;
      res_exp = '0;
      last    = 1;
   endtask

   task automatic model_edge();
      int a, b;
      n++;
      if (RESET) begin
         model_reset();
         return;
      end
      if ((REQ0 || REQ1) && n >= g_edge + lat + 2) begin
         if (REQ0 && REQ1) who = 1 - last;
         else              who = REQ1 ? 1 : 0;
         last = who;
         a    = who ? int'(A1) : int'(A0);
         b    = who ? int'(B1) : int'(B0);
         prod = 8'((a * b) % 256);
         lat  = W;
`ifdef MUL_ARB_ZERO_BYPASS_EN
         if (a == 0 || b == 0) lat = 0;
`endif
         g_edge = n;
      end
      if (n == g_edge + lat) res_exp = prod;
   endtask

   task automatic check_all();
      chk("GNT0",   8'(GNT0),  8'(n == g_edge && who == 0));
      chk("GNT1",   8'(GNT1),  8'(n == g_edge && who == 1));
      chk("DONE0",  8'(DONE0), 8'(n == g_edge + lat && who == 0));
      chk("DONE1",  8'(DONE1), 8'(n == g_edge + lat && who == 1));
      chk("BUSY",   8'(BUSY),  8'(n >= g_edge && n <= g_edge + lat));
      chk("RESULT", RESULT,    res_exp);
      chk("GNT_EXCL",  8'(GNT0 & GNT1),   8'd0);
      chk("DONE_EXCL", 8'(DONE0 & DONE1), 8'd0);
   endtask

   task automatic tick();
      @(posedge CLK);
      model_edge();
      #1;
      check_all();
      @(negedge CLK);
   endtask

   initial begin
      // Reset state
      RESET = 1'b1;
      model_reset();
      #2;
      check_all();
      @(negedge CLK);
      tick();
      tick();
      RESET = 1'b0;
      tick();

      // Single request 5x6
      A0 = 8'd5; B0 = 8'd6; REQ0 = 1'b1;
      tick();
      REQ0 = 1'b0;
      repeat (W + 3) tick();
      chk("R025_RESULT", RESULT, 8'd30);

      // Simultaneous requests after reset: 0 first, then 1 with wrap
      RESET = 1'b1;
      model_reset();
      tick();
      RESET = 1'b0;
      A0 = 8'd10; B0 = 8'd10; A1 = 8'd255; B1 = 8'd2;
      REQ0 = 1'b1; REQ1 = 1'b1;
      tick();
      chk("R026_GNT0_FIRST", 8'(GNT0), 8'd1);
      REQ0 = 1'b0;
      repeat (W + 1) tick();
      chk("R026_RES0", RESULT, 8'd100);
      tick();
      chk("R026_GNT1_SECOND", 8'(GNT1), 8'd1);
      REQ1 = 1'b0;
      repeat (W) tick();
      chk("R026_RES1", RESULT, 8'd254);
      tick();

      // Both held for four operations with changing operands
      REQ0 = 1'b1; REQ1 = 1'b1;
      for (int i = 0; i < 4 * (W + 2) + 1; i++) begin
         A0 = 8'($urandom_range(1, 255)); B0 = 8'($urandom_range(1, 255));
         A1 = 8'($urandom_range(1, 255)); B1 = 8'($urandom_range(1, 255));
         tick();
      end
      REQ0 = 1'b0; REQ1 = 1'b0;
      repeat (W + 2) tick();

      // Operand change during WAIT is ignored
      A0 = 8'd15; B0 = 8'd15; REQ0 = 1'b1;
      tick();
      REQ0 = 1'b0; A0 = 8'd3;
      repeat (W + 1) tick();
      chk("R028_RESULT", RESULT, 8'd225);
      tick();

      // Reset in the first WAIT cycle abandons the operation
      A0 = 8'd7; B0 = 8'd9; REQ0 = 1'b1;
      tick();
      REQ0 = 1'b0;
      #1 RESET = 1'b1;
      model_reset();
      #1;
      check_all();
      tick();
      RESET = 1'b0;
      repeat (W + 2) tick();
      REQ0 = 1'b1;
      tick();
      REQ0 = 1'b0;
      repeat (W + 1) tick();
      chk("R029_RESULT", RESULT, 8'd63);

      // Zero operand
      A0 = 8'd0; B0 = 8'h77; REQ0 = 1'b1;
      tick();
      REQ0 = 1'b0;
      repeat (W + 1) tick();
      chk("R030_RESULT", RESULT, 8'd0);

      // Random traffic with occasional asynchronous reset
      for (int i = 0; i < 400; i++) begin
         REQ0 = ($urandom_range(0, 2) != 0);
         REQ1 = ($urandom_range(0, 2) != 0);
         A0 = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
         B0 = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
         A1 = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
         B1 = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
         if ($urandom_range(0, 99) == 0) begin
            RESET = 1'b1;
            model_reset();
            #1;
            check_all();
         end else begin
            RESET = 1'b0;
         end
         tick();
      end
      RESET = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0;
      repeat (W + 2) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
